// File: rtl/bus_arbiter_reg.sv
// bus_arbiter_reg
//   Registered datapath bus arbiter. Each source presents a data word and a
//   request (out-enable). One source is granted per cycle, and its data is
//   registered onto bus_out together with its index. A granted source can hold
//   the bus across cycles by asserting lock. More than one request in a
//   cycle is reported as a conflict and counted in a saturating counter.
//
//   Optional build macro:
//     BUS_RR_EN  defined   -> round-robin arbitration. The search starts just
//                             after the last IDLE-state grant.
//                undefined -> fixed priority; the lowest index wins.
//
//   Ports:
//     clk          in   rising-edge clock
//     clr          in   asynchronous active-high reset
//     src_data     in   N_SRC*DATA_W packed source data, source i at [i*DATA_W +: DATA_W]
//     src_out      in   N_SRC per-source bus requests
//     lock         in   keep the current grant across cycles
//     bus_out      out  registered bus value
//     bus_valid    out  bus_out was loaded by a granted source on the last edge
//     bus_src      out  index of the source that drove bus_out
//     conflict     out  registered flag: two or more requests seen in the last cycle
//     conflict_cnt out  saturating count of conflict cycles
module bus_arbiter_reg #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 24,
    parameter int ID_W   = 5,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_out,
    input  logic                    lock,
    output logic [DATA_W-1:0]       bus_out,
    output logic                    bus_valid,
    output logic [ID_W-1:0]         bus_src,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_valid_q, bus_valid_d;
    logic [ID_W-1:0]     bus_src_q, bus_src_d;
    logic                conflict_q, conflict_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                owner_req;
    logic [5:0]          n_req;
    logic                arb_any;
    logic [ID_W-1:0]     arb_idx;
    logic                grant_any;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   grant_data;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [ID_W-1:0] lowest_set(input logic [N_SRC-1:0] v);
        logic [ID_W-1:0] r;
        r = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) r = ID_W'(i);
        end
        return r;
    endfunction

    // Request of the current lock owner, and number of active requests.
    always_comb begin
        owner_req = 1'b0;
        n_req     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (owner_q == ID_W'(i)) owner_req = src_out[i];
            n_req = n_req + {5'd0, src_out[i]};
        end
    end

`ifdef BUS_RR_EN
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W:0]        rr_start;
    logic [ID_W:0]        rr_sum;
    logic [2*N_SRC-1:0]   rr_dbl;

    // Rotate the requests so that index rr_ptr+1 lands at bit 0, find the
    // first set bit, then map the offset back to a source index mod N_SRC.
    always_comb begin
        rr_start = (rr_ptr_q == ID_W'(N_SRC - 1)) ? '0
                                                  : ({1'b0, rr_ptr_q} + (ID_W+1)'(1));
        rr_dbl   = {src_out, src_out} >> rr_start;
        rr_sum   = rr_start + {1'b0, lowest_set(rr_dbl[N_SRC-1:0])};
        if (rr_sum >= (ID_W+1)'(N_SRC)) rr_sum = rr_sum - (ID_W+1)'(N_SRC);
        arb_any  = |src_out;
        arb_idx  = rr_sum[ID_W-1:0];
    end
`else
    always_comb begin
        arb_any = |src_out;
        arb_idx = lowest_set(src_out);
    end
`endif

    // Grant selection, FSM next state and output register inputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_out_d   = bus_out_q;
        bus_src_d   = bus_src_q;
        bus_valid_d = 1'b0;
        grant_any   = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
`ifdef BUS_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        // Conflicts count even when the extra requests are blocked by a lock.
        conflict_d  = (n_req >= 6'd2);
        cnt_d       = cnt_q;
        if (conflict_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

        if ((state_q == LOCKED) && lock && owner_req) begin
            grant_any = 1'b1;
            grant_idx = owner_q;
        end else begin
            // Covers lock release too: arbitration happens in the same cycle,
            // so no bubble is inserted.
            state_d = IDLE;
            if (arb_any) begin
                grant_any = 1'b1;
                grant_idx = arb_idx;
`ifdef BUS_RR_EN
                rr_ptr_d  = arb_idx;
`endif
                if (lock) begin
                    state_d = LOCKED;
                    owner_d = arb_idx;
                end
            end
        end

        for (int i = 0; i < N_SRC; i++) begin
            if (grant_idx == ID_W'(i)) grant_data = src_data[i*DATA_W +: DATA_W];
        end

        if (grant_any) begin
            bus_out_d   = grant_data;
            bus_src_d   = grant_idx;
            bus_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_src_q   <= '0;
            conflict_q  <= 1'b0;
            cnt_q       <= '0;
`ifdef BUS_RR_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            bus_src_q   <= bus_src_d;
            conflict_q  <= conflict_d;
            cnt_q       <= cnt_d;
`ifdef BUS_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus_out      = bus_out_q;
    assign bus_valid    = bus_valid_q;
    assign bus_src      = bus_src_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_reg.sv
// Testbench for bus_arbiter_reg. The stimulus driver pushes the expected
// registered outputs into a scoreboard queue. A separate monitor pops and
// compares them one cycle later. Works with or without BUS_RR_EN.
module tb_bus_arbiter_reg;

    localparam int DATA_W  = 32;
    localparam int N_SRC   = 24;
    localparam int ID_W    = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    clr = 1'b0;
    logic [N_SRC*DATA_W-1:0] src_data = '0;
    logic [N_SRC-1:0]        src_out = '0;
    logic                    lock = 1'b0;
    logic [DATA_W-1:0]       bus_out;
    logic                    bus_valid;
    logic [ID_W-1:0]         bus_src;
    logic                    conflict;
    logic [CNT_W-1:0]        conflict_cnt;

    bus_arbiter_reg #(
        .DATA_W(DATA_W), .N_SRC(N_SRC), .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .lock(lock),
        .bus_out(bus_out), .bus_valid(bus_valid), .bus_src(bus_src),
        .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic [ID_W-1:0]   src;
        logic              conf;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model state: who holds a lock, last bus contents, counter.
    bit                m_locked;
    int                m_owner;
    int                m_cnt;
    logic [DATA_W-1:0] m_data;
    int                m_src;
`ifdef BUS_RR_EN
    int                m_rr;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [N_SRC-1:0] r);
`ifdef BUS_RR_EN
        for (int k = 1; k <= N_SRC; k++) begin
            int idx;
            idx = (m_rr + k) % N_SRC;
            if (r[idx]) return idx;
        end
`else
        for (int i = 0; i < N_SRC; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_data   = '0;
        m_src    = 0;
`ifdef BUS_RR_EN
        m_rr     = 0;
`endif
    endtask

    // Apply one cycle of inputs (no clock wait) and push the expected result.
    task automatic apply(input logic [N_SRC-1:0] req, input logic lk,
                         input int slot, input logic [DATA_W-1:0] val);
        exp_t e;
        int   g;
        for (int i = 0; i < N_SRC; i++) src_data[i*DATA_W +: DATA_W] = $urandom();
        if (slot >= 0) src_data[slot*DATA_W +: DATA_W] = val;
        src_out = req;
        lock    = lk;

        e.conf = ($countones(req) >= 2);
        if (e.conf && m_cnt < CNT_MAX) m_cnt++;

        g = -1;
        if (m_locked && lk && req[m_owner]) begin
            g = m_owner;
        end else begin
            m_locked = 0;
            if (req != '0) begin
                g = pick(req);
`ifdef BUS_RR_EN
                m_rr = g;
`endif
                if (lk) begin
                    m_locked = 1;
                    m_owner  = g;
                end
            end
        end
        if (g >= 0) begin
            m_data  = src_data[g*DATA_W +: DATA_W];
            m_src   = g;
            e.valid = 1'b1;
        end else begin
            e.valid = 1'b0;
        end
        e.data = m_data;
        e.src  = ID_W'(m_src);
        e.cnt  = CNT_W'(m_cnt);
        sbq.push_back(e);
    endtask

    task automatic drive(input logic [N_SRC-1:0] req, input logic lk,
                         input int slot, input logic [DATA_W-1:0] val);
        @(negedge clk);
        apply(req, lk, slot, val);
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic do_reset();
        @(negedge clk);
        clr     = 1'b1;
        src_out = '0;
        lock    = 1'b0;
        #1;
        check("rst_bus_out",   32'(bus_out),      32'h0);
        check("rst_bus_valid", 32'(bus_valid),    32'h0);
        check("rst_bus_src",   32'(bus_src),      32'h0);
        check("rst_conflict",  32'(conflict),     32'h0);
        check("rst_cnt",       32'(conflict_cnt), 32'h0);
        model_reset();
        sbq.delete();
        @(negedge clk);
        clr = 1'b0;
        apply('0, 1'b0, -1, '0);
    endtask

    // Scoreboard monitor: one expected entry per clock edge outside reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!clr && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("bus_valid",    32'(bus_valid),    32'(e.valid));
                check("bus_out",      32'(bus_out),      32'(e.data));
                check("bus_src",      32'(bus_src),      32'(e.src));
                check("conflict",     32'(conflict),     32'(e.conf));
                check("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [N_SRC-1:0] req, prev_req;
        int               exp_seq[4];
        model_reset();
        do_reset();

        // Single request with a known word.
        drive(N_SRC'(1) << 5, 1'b0, 5, 32'hDEADBEEF);
        @(posedge clk); #2;
        check("single_src5_data", 32'(bus_out), 32'hDEADBEEF);

        // Two requests held long enough to saturate the conflict counter.
        for (int i = 0; i < 300; i++) drive((N_SRC'(1) << 3) | (N_SRC'(1) << 7), 1'b0, -1, '0);
        @(posedge clk); #2;
        check("cnt_saturated", 32'(conflict_cnt), 32'(CNT_MAX));

        // Lock on source 7, contention from 2, then release.
        do_reset();
        drive(N_SRC'(1) << 7, 1'b1, -1, '0);
        for (int i = 0; i < 3; i++) drive((N_SRC'(1) << 7) | (N_SRC'(1) << 2), 1'b1, -1, '0);
        @(posedge clk); #2;
        check("lock_holds_src7", 32'(bus_src), 32'd7);
        drive((N_SRC'(1) << 7) | (N_SRC'(1) << 2), 1'b0, -1, '0);
        @(posedge clk); #2;
`ifdef BUS_RR_EN
        check("unlock_rr_src", 32'(bus_src), 32'd2);
`else
        check("unlock_src2", 32'(bus_src), 32'd2);
`endif

        // Idle after a transfer keeps the bus contents.
        drive(N_SRC'(1), 1'b0, 0, 32'h0000_1234);
        drive('0, 1'b0, -1, '0);
        @(posedge clk); #2;
        check("idle_hold_data", 32'(bus_out), 32'h0000_1234);
        drive('0, 1'b1, -1, '0);
        drive(N_SRC'(1) << 6, 1'b0, -1, '0);

        // Reset in the middle of a lock aborts it.
        drive(N_SRC'(1) << 4, 1'b1, -1, '0);
        drive((N_SRC'(1) << 4) | (N_SRC'(1) << 1), 1'b1, -1, '0);
        do_reset();
        drive((N_SRC'(1) << 4) | (N_SRC'(1) << 1), 1'b1, -1, '0);
        @(posedge clk); #2;
        check("post_reset_unlocked", 32'(bus_src), 32'd1);

        // Requests {1,4,9} held: round-robin rotates, fixed priority sticks at 1.
        do_reset();
`ifdef BUS_RR_EN
        exp_seq = '{1, 4, 9, 1};
`else
        exp_seq = '{1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) begin
            drive((N_SRC'(1) << 1) | (N_SRC'(1) << 4) | (N_SRC'(1) << 9), 1'b0, -1, '0);
            @(posedge clk); #2;
            check("arb_sequence", 32'(bus_src), 32'(exp_seq[k]));
        end

        // Randomised traffic with sticky requests so that locks persist.
        prev_req = '0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       req = '0;
                1:       req = N_SRC'(1) << $urandom_range(0, N_SRC - 1);
                default: req = N_SRC'($urandom() & $urandom() & $urandom());
            endcase
            if ($urandom_range(0, 3) == 0) req = req | prev_req;
            prev_req = req;
            drive(req, ($urandom_range(0, 3) != 0), -1, '0);
            if (i == 300) do_reset();
        end

        drive('0, 1'b0, -1, '0);
        @(posedge clk); #2;
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
